avst_pkt_gen: RTL and testbench
===============================

Name: avst_pkt_gen

Overview:
Avalon-ST packet transmitter that generates the traffic consumed by a design's 128-bit packet sink. It accepts one command per packet (length, seed, channel) and emits a deterministic byte-pattern packet with SOP/EOP/empty framing under ready/valid backpressure. It is used as the stimulus source in simulation benches, driving any block with a data_in_* style sink port.

Parameters:
DATA_WIDTH, 128, beat width in bits; must be a multiple of 8, with DATA_WIDTH/8 a power of 2
EMPTY_WIDTH, $clog2(DATA_WIDTH/8), width of empty field (derived, not overridden)
LEN_WIDTH, 16, width of packet byte-length command field

Ports:
clk  in  1  single clock, all logic rising-edge
areset_n  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_len  in  LEN_WIDTH  packet length in bytes
cmd_seed  in  8  value of byte 0 of payload
cmd_channel  in  1  channel tag for whole packet
data_out_data  out  DATA_WIDTH  beat payload; first byte in bits [DATA_WIDTH-1 -: 8]
data_out_startofpacket  out  1  first beat of packet
data_out_endofpacket  out  1  last beat of packet
data_out_channel  out  1  latched cmd_channel
data_out_empty  out  EMPTY_WIDTH  unused bytes on EOP beat
data_out_valid  out  1  beat valid
data_out_ready  in  1  sink ready (ready latency 0)
busy  out  1  high while in SEND
zero_len_err  out  1  one-cycle pulse when a cmd_len==0 command is accepted
pkt_count  out  32  packets fully sent since reset, wraps at 2^32

Behaviour:
- Reset (areset_n low, async): state IDLE; all outputs 0 except cmd_ready=1 after reset deasserts; pkt_count=0. Counters and latched command fields cleared.
- BYTES = DATA_WIDTH/8 (16 at default).
- FSM states:
  - IDLE: cmd_ready=1, data_out_valid=0. On cmd_valid, if cmd_len!=0: latch len, seed, channel; set remaining=len and next_byte=seed; go to SEND next cycle. If cmd_len==0: stay in IDLE, pulse zero_len_err next cycle, pkt_count unchanged.
  - SEND: cmd_ready=0, busy=1, data_out_valid=1. A beat is transferred on valid & ready.
- Payload: byte lane k (k=0 at MSB) = next_byte + k mod 256. After each transfer, next_byte += BYTES mod 256 and remaining -= BYTES.
- Beat count = ceil(len/BYTES).
- SOP is 1 on the first beat only.
- EOP is 1 when remaining <= BYTES. On the EOP beat, empty = BYTES - remaining (0 when remaining==BYTES); lanes beyond remaining are driven 0. Empty is 0 on non-EOP beats.
- data_out_channel is held constant for the whole packet.
- Backpressure: while valid & !ready, data, SOP, EOP, empty and channel are held stable and valid stays 1. Valid never deasserts mid-packet.
- On the EOP transfer: pkt_count += 1, state goes to IDLE. One idle cycle (cmd_ready=1) separates packets, so minimum gap is 1 cycle.
- Single-beat packet: SOP and EOP asserted together.
- Max len = 2^LEN_WIDTH - 1; remaining arithmetic is LEN_WIDTH bits with no overflow.
- Reset mid-packet: output drops to valid=0 immediately (async). The partial packet is abandoned and pkt_count is not incremented.
- Outputs are registered. First beat is valid the cycle after command acceptance (latency 1).

Test Plan:
- cmd_len=16, seed=0x00, channel=1, ready=1 -> one beat: data=0x000102...0F, SOP=EOP=1, empty=0, channel=1; pkt_count=1.
- cmd_len=17, seed=0xF8 -> beat0 data=0xF8F9...FF0001...07 (SOP=1, EOP=0); beat1 MSB byte=0x08, other bytes 0, EOP=1, empty=15.
- cmd_len=48 with ready toggled 1,0,0,1,0,1 -> 3 beats; outputs stable during ready=0; beat contents match incrementing pattern; valid continuous.
- cmd_len=0 -> cmd_ready stays 1, zero_len_err pulses once, no valid, pkt_count unchanged; next cmd_len=1, seed=0xAA -> single beat, MSB byte 0xAA, empty=15.
- cmd_len=64, areset_n low after 2 beats -> valid=0 asynchronously, pkt_count=0; after release, a new cmd_len=16 packet sends correctly with SOP.
- Back-to-back commands held valid -> exactly one idle cycle between EOP of packet N and SOP of packet N+1; pkt_count increments per packet.

Source files
------------

// File: rtl/avst_pkt_gen.sv
// avst_pkt_gen: Avalon-ST transmitter emitting one incrementing byte-pattern packet per command
module avst_pkt_gen #(
  parameter int DATA_WIDTH = 128,
  parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH/8),
  parameter int LEN_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic [7:0]             cmd_seed,
  input  logic                   cmd_channel,
  output logic [DATA_WIDTH-1:0]  data_out_data,
  output logic                   data_out_startofpacket,
  output logic                   data_out_endofpacket,
  output logic                   data_out_channel,
  output logic [EMPTY_WIDTH-1:0] data_out_empty,
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic                   busy,
  output logic                   zero_len_err,
  output logic [31:0]            pkt_count
);
  localparam int BYTES = DATA_WIDTH/8;
  localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(BYTES);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [LEN_WIDTH-1:0] rem;
  logic [7:0] nb;
  logic chan, first, eop, fire, accept;
  assign eop = rem <= BYTES_L;
  assign fire = state == SEND && data_out_ready;
  assign accept = state == IDLE && cmd_valid;
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? ((cmd_valid && cmd_len != '0) ? SEND : IDLE)
                              : ((fire && eop) ? IDLE : SEND);
  // Beat fields only move on a transfer, so they hold under backpressure.
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      rem <= '0;
      nb <= '0;
      chan <= 1'b0;
      first <= 1'b0;
      zero_len_err <= 1'b0;
      pkt_count <= '0;
    end else begin
      zero_len_err <= accept && cmd_len == '0;
      if (accept && cmd_len != '0) begin
        rem <= cmd_len;
        nb <= cmd_seed;
        chan <= cmd_channel;
        first <= 1'b1;
      end else if (fire) begin
        rem <= eop ? '0 : rem - BYTES_L;
        nb <= nb + 8'(BYTES);
        first <= 1'b0;
        if (eop) pkt_count <= pkt_count + 32'd1;
      end
    end
  always_comb begin
    cmd_ready = state == IDLE && areset_n;
    busy = state == SEND;
    data_out_valid = busy;
    data_out_startofpacket = busy && first;
    data_out_endofpacket = busy && eop;
    data_out_channel = busy && chan;
    data_out_empty = (busy && eop) ? EMPTY_WIDTH'(BYTES_L - rem) : '0;
    data_out_data = '0;
    for (int k = 0; k < BYTES; k++)
      data_out_data[DATA_WIDTH-1-8*k -: 8] = (busy && !(eop && LEN_WIDTH'(k) >= rem)) ? nb + 8'(k) : 8'h00;
  end
endmodule

// File: tb/tb_avst_pkt_gen.sv
// tb_avst_pkt_gen: table vectors, corner sequences and random packets scored against a byte-level model
module tb_avst_pkt_gen;
  typedef struct { logic [127:0] data; logic sop, eop, ch; logic [3:0] empty; } beat_t;
  typedef struct { int len; logic [7:0] seed; logic ch; } cmd_t;
  typedef struct { int len; logic [7:0] seed; logic ch; int beats; logic [127:0] first, last; logic [3:0] empty; } vec_t;
  logic clk = 0, areset_n = 1, cmd_valid = 0, cmd_channel = 0, data_out_ready = 1;
  logic cmd_ready, data_out_startofpacket, data_out_endofpacket, data_out_channel, data_out_valid, busy, zero_len_err;
  logic [15:0] cmd_len = 0;
  logic [7:0] cmd_seed = 0;
  logic [127:0] data_out_data;
  logic [3:0] data_out_empty;
  logic [31:0] pkt_count;
  int ncmp = 0, nfail = 0, pkt_done = 0, exp_pkts = 0, cyc = 0, last_eop = 0, rdy_mode = 0, pi = 0;
  logic [5:0] pat = 6'b101001;
  logic in_pkt = 0, prev_stall = 0;
  beat_t prev, b_now;
  beat_t cur[$], last_pkt[$];
  cmd_t exp_q[$];
  int gaps[$];
  vec_t vt[5];

  avst_pkt_gen dut (.clk(clk), .areset_n(areset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_seed(cmd_seed), .cmd_channel(cmd_channel), .data_out_data(data_out_data),
    .data_out_startofpacket(data_out_startofpacket), .data_out_endofpacket(data_out_endofpacket),
    .data_out_channel(data_out_channel), .data_out_empty(data_out_empty), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .busy(busy), .zero_len_err(zero_len_err), .pkt_count(pkt_count));

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [127:0] a, logic [127:0] e);
    ncmp++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endfunction

  // Expected packet is rebuilt byte by byte from the command: byte i = seed + i for i < len.
  function automatic void score();
    cmd_t c;
    int nb;
    logic [127:0] d;
    chk("pending_cmds", 128'(exp_q.size() > 0), 128'd1);
    if (exp_q.size() == 0) begin
      cur.delete();
      return;
    end
    c = exp_q.pop_front();
    nb = (c.len + 15) / 16;
    chk("beats", 128'(cur.size()), 128'(nb));
    for (int i = 0; i < nb && i < cur.size(); i++) begin
      d = '0;
      for (int k = 0; k < 16; k++)
        if (i*16 + k < c.len) d[127-8*k -: 8] = 8'(int'(c.seed) + i*16 + k);
      chk("data", cur[i].data, d);
      chk("framing", 128'({cur[i].sop, cur[i].eop, cur[i].empty, cur[i].ch}),
          128'({i == 0, i == nb-1, (i == nb-1) ? 4'(nb*16 - c.len) : 4'd0, c.ch}));
    end
    last_pkt = cur;
    cur.delete();
    pkt_done++;
  endfunction

  always @(posedge clk) begin
    #1;
    pi = (pi + 1) % 6;
    data_out_ready = rdy_mode == 1 ? 1'($urandom_range(0, 1)) : rdy_mode == 2 ? pat[pi] : 1'b1;
  end

  always @(negedge clk) begin
    cyc++;
    if (!areset_n) begin
      cur.delete();
      in_pkt = 0;
      prev_stall = 0;
    end else begin
      chk("busy_eq_valid", 128'(busy), 128'(data_out_valid));
      if (in_pkt) chk("valid_cont", 128'(data_out_valid), 128'd1);
      b_now = '{data_out_data, data_out_startofpacket, data_out_endofpacket, data_out_channel, data_out_empty};
      if (prev_stall) begin
        chk("hold_data", data_out_data, prev.data);
        chk("hold_ctl", 128'({data_out_valid, b_now.sop, b_now.eop, b_now.ch, b_now.empty}),
            128'({1'b1, prev.sop, prev.eop, prev.ch, prev.empty}));
      end
      if (data_out_valid && data_out_startofpacket && !prev_stall) gaps.push_back(cyc - last_eop);
      prev_stall = data_out_valid && !data_out_ready;
      prev = b_now;
      if (data_out_valid && data_out_ready) begin
        cur.push_back(b_now);
        in_pkt = !b_now.eop;
        if (b_now.eop) begin
          last_eop = cyc;
          score();
        end
      end
    end
  end

  task automatic issue(input int len, input logic [7:0] seed, input logic ch);
    cmd_t c;
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1;
    cmd_len = 16'(len);
    cmd_seed = seed;
    cmd_channel = ch;
    while (!cmd_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 128'(cmd_ready), 128'd1);
    @(posedge clk);
    #1 cmd_valid = 0;
    if (len != 0) begin
      c = '{len, seed, ch};
      exp_q.push_back(c);
      exp_pkts++;
    end
  endtask

  task automatic wait_done(input int tgt);
    int n;
    n = 0;
    while (pkt_done < tgt && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_done", 128'(pkt_done >= tgt), 128'd1);
    @(negedge clk);
    chk("pkt_count", 128'(pkt_count), 128'(exp_pkts));
  endtask

  initial begin
    int tgt, n, cnt, g0;
    vt[0] = '{16, 8'h00, 1'b1, 1, 128'h000102030405060708090A0B0C0D0E0F, 128'h000102030405060708090A0B0C0D0E0F, 4'd0};
    vt[1] = '{17, 8'hF8, 1'b0, 2, 128'hF8F9FAFBFCFDFEFF0001020304050607, 128'h08000000000000000000000000000000, 4'd15};
    vt[2] = '{1, 8'hAA, 1'b1, 1, 128'hAA000000000000000000000000000000, 128'hAA000000000000000000000000000000, 4'd15};
    vt[3] = '{32, 8'h10, 1'b0, 2, 128'h101112131415161718191A1B1C1D1E1F, 128'h202122232425262728292A2B2C2D2E2F, 4'd0};
    vt[4] = '{20, 8'hFE, 1'b1, 2, 128'hFEFF000102030405060708090A0B0C0D, 128'h0E0F1011000000000000000000000000, 4'd12};
    #2 areset_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 128'({data_out_valid, busy, zero_len_err, data_out_startofpacket, data_out_endofpacket, data_out_empty}), 128'd0);
    chk("rst_count", 128'(pkt_count), 128'd0);
    chk("rst_data", data_out_data, 128'd0);
    areset_n = 1;
    @(negedge clk);
    chk("rst_cmd_ready", 128'(cmd_ready), 128'd1);
    // Zero-length command: error pulse only, no traffic.
    cnt = pkt_count;
    issue(0, 8'h55, 1'b1);
    @(negedge clk);
    chk("zlen_pulse", 128'({zero_len_err, data_out_valid}), 128'b10);
    @(negedge clk);
    chk("zlen_clear", 128'({zero_len_err, data_out_valid, cmd_ready}), 128'b001);
    chk("zlen_count", 128'(pkt_count), 128'(cnt));
    foreach (vt[i]) begin
      tgt = pkt_done + 1;
      issue(vt[i].len, vt[i].seed, vt[i].ch);
      wait_done(tgt);
      chk("tbl_beats", 128'(last_pkt.size()), 128'(vt[i].beats));
      if (last_pkt.size() > 0) begin
        chk("tbl_first", last_pkt[0].data, vt[i].first);
        chk("tbl_last", last_pkt[last_pkt.size()-1].data, vt[i].last);
        chk("tbl_empty", 128'(last_pkt[last_pkt.size()-1].empty), 128'(vt[i].empty));
        chk("tbl_chan", 128'(last_pkt[0].ch), 128'(vt[i].ch));
      end
    end
    rdy_mode = 2;
    tgt = pkt_done + 1;
    issue(48, 8'h30, 1'b0);
    wait_done(tgt);
    chk("bp_beats", 128'(last_pkt.size()), 128'd3);
    rdy_mode = 0;
    // Abandon a packet mid-flight with an async reset.
    issue(64, 8'h40, 1'b1);
    n = 0;
    while (cur.size() < 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_beats", 128'(cur.size() >= 2), 128'd1);
    @(posedge clk);
    #3 areset_n = 0;
    #1;
    chk("async_valid", 128'({data_out_valid, busy}), 128'd0);
    chk("async_count", 128'(pkt_count), 128'd0);
    exp_q.delete();
    exp_pkts = 0;
    @(negedge clk);
    @(negedge clk);
    areset_n = 1;
    tgt = pkt_done + 1;
    issue(16, 8'h11, 1'b0);
    wait_done(tgt);
    chk("post_rst_sop", 128'(last_pkt.size() > 0 && last_pkt[0].sop), 128'd1);
    g0 = gaps.size();
    tgt = pkt_done + 3;
    issue(20, 8'h01, 1'b0);
    issue(5, 8'h02, 1'b1);
    issue(33, 8'h03, 1'b0);
    wait_done(tgt);
    chk("b2b_gaps", 128'(gaps.size() >= g0 + 3), 128'd1);
    if (gaps.size() >= g0 + 3) begin
      chk("gap1", 128'(gaps[g0+1]), 128'd2);
      chk("gap2", 128'(gaps[g0+2]), 128'd2);
    end
    rdy_mode = 1;
    for (int i = 0; i < 25; i++) begin
      tgt = pkt_done + 1;
      issue((i % 5 == 0) ? int'($urandom_range(81, 300)) : int'($urandom_range(1, 80)),
            8'($urandom), 1'($urandom));
      wait_done(tgt);
    end
    rdy_mode = 0;
    tgt = pkt_done + 1;
    issue(65535, 8'h7F, 1'b1);
    wait_done(tgt);
    chk("max_beats", 128'(last_pkt.size()), 128'd4096);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
